cmp_result_monitor: RTL and testbench

- Sits directly downstream of the 5-bit magnitude comparator and consumes its AeqB/AgtB/AltB flags, one sample per cycle when in_valid is high.
- Keeps saturating tallies of each outcome.
- Detects sustained A>B or A<B runs and raises a sticky alarm with hysteresis.
- Flags any sample whose three flags are not one-hot.

---
 rtl/cmp_result_monitor_pkg.sv | 44 ++++
 rtl/cmp_result_monitor_sat_counter.sv | 31 +++
 rtl/cmp_result_monitor.sv | 242 ++++++++++++++++++++++++
 tb/tb_cmp_result_monitor.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_result_monitor_pkg.sv
// ---------------------------------------------------------------------------
// cmp_mon_pkg
//   Shared definitions for the comparator result monitor:
//   - state_t  : run / alarm FSM states
//   - sample_t : classification of one {aeqb,agtb,altb} sample
//   - FLAG_*   : the three legal one-hot flag patterns
//   - classify : maps a raw flag triple onto sample_t
// ---------------------------------------------------------------------------
package cmp_mon_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GT_RUN,
        S_LT_RUN,
        S_GT_ALARM,
        S_LT_ALARM
    } state_t;

    typedef enum logic [1:0] {
        SMP_EQ,
        SMP_GT,
        SMP_LT,
        SMP_ERR
    } sample_t;

    // Flag order is {aeqb, agtb, altb}
    localparam logic [2:0] FLAG_EQ = 3'b100;
    localparam logic [2:0] FLAG_GT = 3'b010;
    localparam logic [2:0] FLAG_LT = 3'b001;

    // Anything other than the three one-hot patterns (including 000 and
    // multi-hot) is a comparator fault.
    function automatic sample_t classify(input logic [2:0] flags);
        sample_t kind;
        case (flags)
            FLAG_EQ: kind = SMP_EQ;
            FLAG_GT: kind = SMP_GT;
            FLAG_LT: kind = SMP_LT;
            default: kind = SMP_ERR;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/cmp_result_monitor_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   W-bit up-counter that sticks at all-ones instead of wrapping.
//
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset (q -> 0)
//   clr    in  synchronous clear (q -> 0), has priority over inc
//   inc    in  add one this cycle (ignored once q is all-ones)
//   q      out current count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/cmp_result_monitor.sv
// ---------------------------------------------------------------------------
// cmp_result_monitor
//   Watches the AeqB/AgtB/AltB flags of a magnitude comparator, one sample
//   per cycle while in_valid is high. Keeps saturating tallies of each
//   outcome, raises a sticky alarm once STREAK consecutive A>B (or A<B)
//   samples are seen, and releases it only after STREAK consecutive
//   non-matching samples. Non-one-hot samples are counted and flagged but
//   never influence the run/alarm tracking.
//
//   Parameters
//     CNT_W   width of each tally (saturates at 2^CNT_W-1)
//     STREAK  samples needed to raise and to release an alarm (2..15)
//
//   Ports
//     clk         in   rising-edge clock
//     rst_n       in   asynchronous active-low reset
//     clear       in   synchronous clear of tallies, alarms and FSM;
//                      a valid sample in the same cycle is dropped
//     in_valid    in   flags below form a sample this cycle
//     aeqb        in   comparator A==B flag
//     agtb        in   comparator A>B flag
//     altb        in   comparator A<B flag
//     eq_cnt      out  valid EQ samples
//     gt_cnt      out  valid GT samples
//     lt_cnt      out  valid LT samples
//     err_cnt     out  valid non-one-hot samples
//     gt_alarm    out  sustained A>B
//     lt_alarm    out  sustained A<B
//     sample_err  out  one-cycle pulse after a non-one-hot valid sample
//
//   All outputs are registered: a sample accepted in cycle N shows up in
//   cycle N+1.
// ---------------------------------------------------------------------------
module cmp_result_monitor
    import cmp_mon_pkg::*;
#(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned STREAK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             aeqb,
    input  logic             agtb,
    input  logic             altb,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             gt_alarm,
    output logic             lt_alarm,
    output logic             sample_err
);

    localparam logic [3:0] STREAK_V = 4'(STREAK);

    // -----------------------------------------------------------------
    // Sample classification
    // -----------------------------------------------------------------
    sample_t kind;
    logic    accept;
    logic    is_eq;
    logic    is_gt;
    logic    is_lt;
    logic    is_err;
    logic    fsm_step;

    always_comb begin
        kind     = classify({aeqb, agtb, altb});
        // clear takes priority: a coincident sample is simply dropped
        accept   = in_valid && !clear;
        is_eq    = accept && (kind == SMP_EQ);
        is_gt    = accept && (kind == SMP_GT);
        is_lt    = accept && (kind == SMP_LT);
        is_err   = accept && (kind == SMP_ERR);
        fsm_step = is_eq || is_gt || is_lt;
    end

    // -----------------------------------------------------------------
    // Outcome tallies
    // -----------------------------------------------------------------
    sat_counter #(.W(CNT_W)) u_eq_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (is_eq),
        .q     (eq_cnt)
    );

    sat_counter #(.W(CNT_W)) u_gt_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (is_gt),
        .q     (gt_cnt)
    );

    sat_counter #(.W(CNT_W)) u_lt_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (is_lt),
        .q     (lt_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (is_err),
        .q     (err_cnt)
    );

    // -----------------------------------------------------------------
    // Fault pulse: high for exactly the cycle after a bad sample
    // -----------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_err <= 1'b0;
        end else begin
            sample_err <= is_err;
        end
    end

    // -----------------------------------------------------------------
    // Run / alarm FSM
    //   run  : length of the current same-direction streak
    //   hold : consecutive samples since the alarm direction was last seen
    // Only valid one-hot samples advance it; ERR samples leave every
    // register untouched.
    // -----------------------------------------------------------------
    state_t     state;
    logic [3:0] run;
    logic [3:0] hold;
    logic [3:0] run_inc;
    logic [3:0] hold_inc;

    always_comb begin
        run_inc  = run + 4'd1;
        hold_inc = hold + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            run      <= '0;
            hold     <= '0;
            gt_alarm <= 1'b0;
            lt_alarm <= 1'b0;
        end else if (clear) begin
            state    <= S_IDLE;
            run      <= '0;
            hold     <= '0;
            gt_alarm <= 1'b0;
            lt_alarm <= 1'b0;
        end else if (fsm_step) begin
            unique case (state)
                S_IDLE: begin
                    if (is_gt) begin
                        state <= S_GT_RUN;
                        run   <= 4'd1;
                    end else if (is_lt) begin
                        state <= S_LT_RUN;
                        run   <= 4'd1;
                    end
                end

                S_GT_RUN: begin
                    if (is_gt) begin
                        run <= run_inc;
                        if (run_inc == STREAK_V) begin
                            state    <= S_GT_ALARM;
                            hold     <= '0;
                            gt_alarm <= 1'b1;
                        end
                    end else if (is_lt) begin
                        state <= S_LT_RUN;
                        run   <= 4'd1;
                    end else begin
                        state <= S_IDLE;
                        run   <= '0;
                    end
                end

                S_LT_RUN: begin
                    if (is_lt) begin
                        run <= run_inc;
                        if (run_inc == STREAK_V) begin
                            state    <= S_LT_ALARM;
                            hold     <= '0;
                            lt_alarm <= 1'b1;
                        end
                    end else if (is_gt) begin
                        state <= S_GT_RUN;
                        run   <= 4'd1;
                    end else begin
                        state <= S_IDLE;
                        run   <= '0;
                    end
                end

                // Opposite-direction samples inside the hold window only
                // count towards release; they never seed a new run.
                S_GT_ALARM: begin
                    if (is_gt) begin
                        hold <= '0;
                    end else begin
                        hold <= hold_inc;
                        if (hold_inc == STREAK_V) begin
                            state    <= S_IDLE;
                            gt_alarm <= 1'b0;
                            run      <= '0;
                        end
                    end
                end

                S_LT_ALARM: begin
                    if (is_lt) begin
                        hold <= '0;
                    end else begin
                        hold <= hold_inc;
                        if (hold_inc == STREAK_V) begin
                            state    <= S_IDLE;
                            lt_alarm <= 1'b0;
                            run      <= '0;
                        end
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    run      <= '0;
                    hold     <= '0;
                    gt_alarm <= 1'b0;
                    lt_alarm <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_result_monitor.sv
// ---------------------------------------------------------------------------
// tb_cmp_result_monitor
//   Directed scoreboard bench. Each driven cycle pushes its expected output
//   set (due one cycle later) into a queue; a monitor on the falling edge
//   pops and compares. Alarm expectations are written by hand per vector;
//   tallies are simple saturating counts of the issued samples. A second
//   instance with CNT_W=3 shares the stimulus to exercise saturation.
// ---------------------------------------------------------------------------
module tb_cmp_result_monitor;
    import cmp_mon_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, clear, in_valid, aeqb, agtb, altb;
    logic [7:0] eq_cnt, gt_cnt, lt_cnt, err_cnt;
    logic       gt_alarm, lt_alarm, sample_err;
    logic [2:0] s_eq_cnt, s_gt_cnt, s_lt_cnt, s_err_cnt;
    logic       s_gt_alarm, s_lt_alarm, s_sample_err;

    cmp_result_monitor #(.CNT_W(8), .STREAK(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .aeqb       (aeqb),
        .agtb       (agtb),
        .altb       (altb),
        .eq_cnt     (eq_cnt),
        .gt_cnt     (gt_cnt),
        .lt_cnt     (lt_cnt),
        .err_cnt    (err_cnt),
        .gt_alarm   (gt_alarm),
        .lt_alarm   (lt_alarm),
        .sample_err (sample_err)
    );

    cmp_result_monitor #(.CNT_W(3), .STREAK(4)) dut_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .aeqb       (aeqb),
        .agtb       (agtb),
        .altb       (altb),
        .eq_cnt     (s_eq_cnt),
        .gt_cnt     (s_gt_cnt),
        .lt_cnt     (s_lt_cnt),
        .err_cnt    (s_err_cnt),
        .gt_alarm   (s_gt_alarm),
        .lt_alarm   (s_lt_alarm),
        .sample_err (s_sample_err)
    );

    typedef struct {
        int         due;
        logic [7:0] eq, gt, lt, err;
        logic       ga, la, se;
        logic [2:0] seq;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   t_eq = 0, t_gt = 0, t_lt = 0, t_err = 0;

    localparam logic [2:0] F111 = 3'b111;
    localparam logic [2:0] F000 = 3'b000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] sat8(input int v);
        return (v > 255) ? 8'd255 : 8'(v);
    endfunction

    function automatic logic [2:0] sat3(input int v);
        return (v > 7) ? 3'd7 : 3'(v);
    endfunction

    // Monitor: compare everything the DUTs present once an entry is due
    always @(negedge clk) begin
        if (q.size() != 0 && q[0].due <= cyc) begin
            cur = q.pop_front();
            chk("eq_cnt",     int'(eq_cnt),       int'(cur.eq));
            chk("gt_cnt",     int'(gt_cnt),       int'(cur.gt));
            chk("lt_cnt",     int'(lt_cnt),       int'(cur.lt));
            chk("err_cnt",    int'(err_cnt),      int'(cur.err));
            chk("gt_alarm",   int'(gt_alarm),     int'(cur.ga));
            chk("lt_alarm",   int'(lt_alarm),     int'(cur.la));
            chk("sample_err", int'(sample_err),   int'(cur.se));
            chk("small_eq",   int'(s_eq_cnt),     int'(cur.seq));
        end
    end

    // Drive one cycle of stimulus and queue the response expected next cycle
    task automatic step(input logic clr, input logic v, input logic [2:0] f,
                        input logic ega, input logic ela);
        exp_t e;
        logic se_x;
        @(negedge clk);
        clear    = clr;
        in_valid = v;
        {aeqb, agtb, altb} = f;
        se_x = 1'b0;
        if (clr) begin
            t_eq = 0; t_gt = 0; t_lt = 0; t_err = 0;
        end else if (v) begin
            if (f == FLAG_EQ)      t_eq++;
            else if (f == FLAG_GT) t_gt++;
            else if (f == FLAG_LT) t_lt++;
            else begin
                t_err++;
                se_x = 1'b1;
            end
        end
        e.due = cyc + 1;
        e.eq  = sat8(t_eq);
        e.gt  = sat8(t_gt);
        e.lt  = sat8(t_lt);
        e.err = sat8(t_err);
        e.ga  = ega;
        e.la  = ela;
        e.se  = se_x;
        e.seq = sat3(t_eq);
        q.push_back(e);
    endtask

    // Let the last driven sample be captured, go idle, wait for the checks
    task automatic drain();
        int n;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
        {aeqb, agtb, altb} = 3'b000;
        #12;
        chk("rst_eq_cnt",   int'(eq_cnt),     0);
        chk("rst_err_cnt",  int'(err_cnt),    0);
        chk("rst_gt_alarm", int'(gt_alarm),   0);
        chk("rst_lt_alarm", int'(lt_alarm),   0);
        chk("rst_sample_err", int'(sample_err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle: invalid cycles with assorted flags change nothing
        for (int i = 0; i < 10; i++) begin
            step(0, 0, (i % 2 == 0) ? F111 : FLAG_GT, 0, 0);
        end

        // GT alarm raise and hold/release
        step(0, 1, FLAG_GT, 0, 0);
        step(0, 1, FLAG_GT, 0, 0);
        step(0, 1, FLAG_GT, 0, 0);
        step(0, 1, FLAG_GT, 1, 0);
        step(0, 1, FLAG_EQ, 1, 0);
        step(0, 1, FLAG_LT, 1, 0);
        step(0, 1, FLAG_GT, 1, 0);   // hold restarts
        step(0, 1, FLAG_EQ, 1, 0);
        step(0, 1, FLAG_EQ, 1, 0);
        step(0, 1, FLAG_LT, 1, 0);
        step(0, 1, FLAG_EQ, 0, 0);   // 4th consecutive non-GT releases
        step(1, 0, F000,    0, 0);

        // LT samples inside a GT hold window do not seed an LT run
        step(0, 1, FLAG_GT, 0, 0);
        step(0, 1, FLAG_GT, 0, 0);
        step(0, 1, FLAG_GT, 0, 0);
        step(0, 1, FLAG_GT, 1, 0);
        step(0, 1, FLAG_LT, 1, 0);
        step(0, 1, FLAG_LT, 1, 0);
        step(0, 1, FLAG_LT, 1, 0);
        step(0, 1, FLAG_LT, 0, 0);
        step(0, 1, FLAG_LT, 0, 0);
        step(0, 1, FLAG_LT, 0, 0);
        step(0, 1, FLAG_LT, 0, 0);
        step(0, 1, FLAG_LT, 0, 1);
        step(1, 0, F000,    0, 0);

        // Broken GT run, then an LT alarm
        step(0, 1, FLAG_GT, 0, 0);
        step(0, 1, FLAG_GT, 0, 0);
        step(0, 1, FLAG_GT, 0, 0);
        step(0, 1, FLAG_EQ, 0, 0);
        step(0, 1, FLAG_GT, 0, 0);
        step(0, 1, FLAG_GT, 0, 0);
        step(0, 1, FLAG_GT, 0, 0);
        step(0, 1, FLAG_EQ, 0, 0);
        step(0, 1, FLAG_GT, 0, 0);
        step(0, 1, FLAG_LT, 0, 0);
        step(0, 1, FLAG_LT, 0, 0);
        step(0, 1, FLAG_LT, 0, 0);
        step(0, 1, FLAG_LT, 0, 1);
        step(1, 0, F000,    0, 0);

        // Non-one-hot samples are counted but skipped by the run logic
        step(0, 1, FLAG_GT, 0, 0);
        step(0, 1, FLAG_GT, 0, 0);
        step(0, 1, F111,    0, 0);
        step(0, 0, FLAG_LT, 0, 0);
        step(0, 1, FLAG_GT, 0, 0);
        step(0, 1, FLAG_GT, 1, 0);
        step(0, 1, F000,    1, 0);
        step(0, 1, 3'b011,  1, 0);
        step(1, 0, F000,    0, 0);

        // Saturation on the 3-bit instance, then clear beats a valid GT
        for (int i = 0; i < 9; i++) begin
            step(0, 1, FLAG_EQ, 0, 0);
        end
        step(0, 1, FLAG_GT, 0, 0);
        step(1, 1, FLAG_GT, 0, 0);
        step(0, 0, FLAG_GT, 0, 0);

        // Asynchronous reset in the middle of an LT alarm
        step(0, 1, FLAG_LT, 0, 0);
        step(0, 1, FLAG_LT, 0, 0);
        step(0, 1, FLAG_LT, 0, 0);
        step(0, 1, FLAG_LT, 0, 1);
        drain();
        @(posedge clk);
        #2;
        chk("pre_rst_lt_alarm", int'(lt_alarm), 1);
        rst_n = 1'b0;
        #1;
        chk("async_lt_alarm", int'(lt_alarm), 0);
        chk("async_lt_cnt",   int'(lt_cnt),   0);
        chk("async_small_lt", int'(s_lt_cnt), 0);
        #4;
        rst_n = 1'b1;
        t_eq = 0; t_gt = 0; t_lt = 0; t_err = 0;
        step(0, 0, FLAG_LT, 0, 0);
        step(0, 1, FLAG_LT, 0, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
